parity_frame_ctrl: RTL and testbench



---
 rtl/parity_pkg.sv | 24 ++
 rtl/parity_frame_ctrl_gen.sv | 21 ++
 rtl/parity_frame_ctrl.sv | 138 +++++++++++++
 tb/tb_parity_frame_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
`default_nettype none
// ============================================================================
// Module      : parity_pkg
// Description : Shared widths, FSM state encodings and the nibble parity
//               helper for the parity frame controller and its generator.
// Revision    : 1.0 - initial release
// ============================================================================
package parity_pkg;

  localparam int WORD_W = 5;
  localparam int NIB_W  = 4;

  // FSM state encodings
  localparam logic [0:0] S_DATA  = 1'b0;
  localparam logic [0:0] S_TRAIL = 1'b1;

  // Parity of one nibble; odd=1 inverts so the 5-bit word has odd ones-count
  function automatic logic nib_parity(input logic [NIB_W-1:0] nibble,
                                      input logic odd);
    return (^nibble) ^ odd;
  endfunction

endpackage
`default_nettype wire

// File: rtl/parity_frame_ctrl_gen.sv
`default_nettype none
// ============================================================================
// Module      : parity_frame_ctrl_gen
// Description : 4-bit parity generator, purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module parity_frame_ctrl_gen
  import parity_pkg::*;
(
  input  logic [NIB_W-1:0] nibble,
  input  logic             odd,
  output logic             parity
);

  // Parity bit straight from the shared helper
  always_comb begin
    parity = nib_parity(nibble, odd);
  end

endmodule
`default_nettype wire

// File: rtl/parity_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : parity_frame_ctrl
// Description : Streams nibbles through the parity generator, appends the
//               parity bit and closes each frame with a {count, parity}
//               trailer word. Build option: ODD_PARITY_EN selects odd parity.
// Revision    : 1.0 - initial release
// ============================================================================
module parity_frame_ctrl
  import parity_pkg::*;
#(
  parameter  int MAX_NIBBLES = 8,
  localparam int CW          = $clog2(MAX_NIBBLES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NIB_W-1:0]  in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_trailer,
  output logic              ovf_pulse,
  output logic [7:0]        frame_cnt
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_NIBBLES);

`ifdef ODD_PARITY_EN
  localparam logic ODD_SEL = 1'b1;
`else
  localparam logic ODD_SEL = 1'b0;
`endif

  logic [0:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              acc_q, acc_d;
  logic              out_valid_q, out_valid_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic              out_trailer_q, out_trailer_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;

  logic              nib_par;
  logic              slot_free;
  logic              accept;
  logic [CW-1:0]     cnt_inc;
  logic              cnt_hit;
  logic [NIB_W-1:0]  cnt_nib;

  parity_frame_ctrl_gen u_gen (
    .nibble (in_data),
    .odd    (ODD_SEL),
    .parity (nib_par)
  );

  // Handshake qualifiers; nothing is accepted while reset is asserted
  always_comb begin
    slot_free = !out_valid_q || out_ready;
    in_ready  = !rst && (state_q == S_DATA) && slot_free;
    accept    = in_valid && in_ready;
    cnt_inc   = cnt_q + 1'b1;
    cnt_hit   = (cnt_inc == MAX_CNT);
    cnt_nib   = NIB_W'(cnt_q);
  end

  // Next-state: FSM, counters, output register and frame counter
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    out_valid_d   = out_valid_q && !out_ready;
    out_data_d    = out_data_q;
    out_trailer_d = out_trailer_q;
    ovf_d         = 1'b0;
    frame_cnt_d   = frame_cnt_q;

    if (out_valid_q && out_ready && out_trailer_q) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end

    if (state_q == S_DATA) begin
      if (accept) begin
        out_data_d    = {in_data, nib_par};
        out_valid_d   = 1'b1;
        out_trailer_d = 1'b0;
        acc_d         = acc_q ^ nib_par;
        cnt_d         = cnt_inc;
        if (in_last || cnt_hit) begin
          state_d = S_TRAIL;
        end
        ovf_d = cnt_hit && !in_last;
      end
    end else begin
      if (slot_free) begin
        out_data_d    = {cnt_nib, acc_q};
        out_valid_d   = 1'b1;
        out_trailer_d = 1'b1;
        acc_d         = 1'b0;
        cnt_d         = '0;
        state_d       = S_DATA;
      end
    end
  end

  // State registers with synchronous reset; a partial frame is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_DATA;
      cnt_q         <= '0;
      acc_q         <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_trailer_q <= 1'b0;
      ovf_q         <= 1'b0;
      frame_cnt_q   <= 8'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_trailer_q <= out_trailer_d;
      ovf_q         <= ovf_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_trailer = out_trailer_q;
  assign ovf_pulse   = ovf_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_parity_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_parity_frame_ctrl
// Description : Self-checking bench for parity_frame_ctrl: table vectors,
//               scoreboard queue of expected output words, corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parity_frame_ctrl;

  localparam int MAX = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_data;
  logic       out_trailer;
  logic       ovf_pulse;
  logic [7:0] frame_cnt;

  parity_frame_ctrl #(.MAX_NIBBLES(MAX)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_trailer (out_trailer),
    .ovf_pulse   (ovf_pulse),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] d;
    logic       last;
    logic [4:0] ew;
    logic [4:0] et;
  } vec_t;

  int          n_vec = 0;
  int          n_err = 0;
  logic [5:0]  sb[$];
  int          m_cnt = 0;
  logic        m_acc = 1'b0;
  int          m_frames = 0;

  // Reference parity, written independently of the design
  function automatic logic pm(input logic [3:0] d);
    logic p;
    p = d[3] ^ d[2] ^ d[1] ^ d[0];
`ifdef ODD_PARITY_EN
    p = ~p;
`endif
    return p;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: compare each word the consumer accepts
  always @(negedge clk) begin
    logic [5:0] e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_word: got %b%b expected none", out_trailer, out_data);
      end else begin
        e = sb.pop_front();
        check("out_word", {2'b00, out_trailer, out_data}, {2'b00, e});
        if (e[5]) m_frames++;
      end
    end
  end

  // Offer one nibble, wait for accept, push expectations, check ovf/in_ready
  task automatic send(input logic [3:0] d, input logic last, input logic [4:0] ew,
                      input logic use_t, input logic [4:0] et);
    int   budget;
    logic closes;
    logic exp_ovf;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    budget   = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      budget++;
      if (budget > 50) begin
        check("accept_timeout", 8'd0, 8'd1);
        in_valid = 1'b0;
        return;
      end
    end
    sb.push_back({1'b0, ew});
    m_cnt++;
    m_acc   = m_acc ^ ew[0];
    closes  = last || (m_cnt == MAX);
    exp_ovf = (m_cnt == MAX) && !last;
    if (closes) begin
      sb.push_back({1'b1, use_t ? et : {4'(m_cnt), m_acc}});
      m_cnt = 0;
      m_acc = 1'b0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 4'h0;
    in_last  = 1'b0;
    @(negedge clk);
    check("ovf_pulse", {7'd0, ovf_pulse}, {7'd0, exp_ovf});
    if (closes) check("in_ready_trail", {7'd0, in_ready}, 8'd0);
  endtask

  task automatic drain_and_count(input int exp_frames);
    int budget;
    budget = 0;
    while (sb.size() != 0 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (sb.size() != 0) check("drain_timeout", 8'(sb.size()), 8'd0);
    @(negedge clk);
    check("frame_cnt", frame_cnt, 8'(m_frames));
    check("frame_cnt_abs", frame_cnt, 8'(exp_frames));
  endtask

  task automatic run_vec(input vec_t v);
`ifdef ODD_PARITY_EN
    send(v.d, v.last, {v.d, pm(v.d)}, 1'b0, 5'd0);
`else
    send(v.d, v.last, v.ew, v.last, v.et);
`endif
  endtask

  vec_t tbl[4];

  initial begin
    // Table: {nibble, last, expected data word, expected trailer (even parity)}
    tbl[0] = '{4'b0001, 1'b0, 5'b00011, 5'b00000};
    tbl[1] = '{4'b0010, 1'b0, 5'b00101, 5'b00000};
    tbl[2] = '{4'b1111, 1'b1, 5'b11110, 5'b00110};
    tbl[3] = '{4'b1110, 1'b1, 5'b11101, 5'b00011};

    rst = 1'b1; in_valid = 1'b0; in_data = 4'h0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("in_ready_in_rst", {7'd0, in_ready}, 8'd0);
    check("rst_out_valid", {7'd0, out_valid}, 8'd0);
    check("rst_out_data", {3'd0, out_data}, 8'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_out_valid", {7'd0, out_valid}, 8'd0);
    check("idle_frame_cnt", frame_cnt, 8'd0);
    check("idle_ovf", {7'd0, ovf_pulse}, 8'd0);
    check("idle_in_ready", {7'd0, in_ready}, 8'd1);

    // Basic three-nibble frame
    for (int i = 0; i < 3; i++) run_vec(tbl[i]);
    drain_and_count(1);

    // Overflow: nine 0101 nibbles, no last until the ninth
    for (int i = 0; i < 9; i++) begin
      if (i == 7) send(4'b0101, 1'b0, {4'b0101, pm(4'b0101)}, 1'b1, 5'b10000);
      else        send(4'b0101, (i == 8), {4'b0101, pm(4'b0101)}, 1'b0, 5'd0);
    end
    drain_and_count(3);

    // Stall: consumer holds off for 5 cycles after the first accept
    @(posedge clk); #1;
    out_ready = 1'b0;
    run_vec(tbl[0]);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {7'd0, out_valid}, 8'd1);
      check("stall_data", {3'd0, out_data}, {3'd0, 4'b0001, pm(4'b0001)});
      check("stall_in_ready", {7'd0, in_ready}, 8'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    run_vec(tbl[1]);
    run_vec(tbl[2]);
    drain_and_count(4);

    // Reset while the frame is closing with the output unaccepted
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(4'b1100, 1'b1, {4'b1100, pm(4'b1100)}, 1'b0, 5'd0);
    check("pre_rst_valid", {7'd0, out_valid}, 8'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("in_ready_rst_mid", {7'd0, in_ready}, 8'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    m_cnt = 0; m_acc = 1'b0; m_frames = 0;
    @(negedge clk);
    check("post_rst_valid", {7'd0, out_valid}, 8'd0);
    check("post_rst_trailer", {7'd0, out_trailer}, 8'd0);
    check("post_rst_frame_cnt", frame_cnt, 8'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    begin
      vec_t v;
      v = '{4'b1100, 1'b1, 5'b11000, 5'b00010};
      run_vec(v);
    end
    drain_and_count(1);

    // Single-nibble frame
    run_vec(tbl[3]);
    drain_and_count(2);

`ifdef ODD_PARITY_EN
    send(4'b0000, 1'b1, 5'b00001, 1'b1, 5'b00011);
    drain_and_count(3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
